// File: rtl/m_stage_ctrl_pipe_if.sv
// E->M handshake and M-stage control bundle for m_stage_ctrl_pipe.
// slave  : the M-stage controller (consumes E outputs, drives M decode).
// master : the surrounding pipeline / hazard unit / data memory side.
interface m_stage_ctrl_pipe_if #(
  parameter int TNEW_W = 2
);
  logic              stall_in;
  logic              flush_in;
  logic [31:0]       instr_e;
  logic [1:0]        addr_e;
  logic              mem_ready;
  logic [31:0]       instr_m;
  logic [TNEW_W-1:0] tnew;
  logic [4:0]        a3;
  logic              memwrite;
  logic              memread;
  logic [3:0]        byte_en;
  logic              jalop;
  logic              change;
  logic              align_err;
  logic              mem_busy;

  modport slave (
    input  stall_in, flush_in, instr_e, addr_e, mem_ready,
    output instr_m, tnew, a3, memwrite, memread, byte_en,
           jalop, change, align_err, mem_busy
  );

  modport master (
    output stall_in, flush_in, instr_e, addr_e, mem_ready,
    input  instr_m, tnew, a3, memwrite, memread, byte_en,
           jalop, change, align_err, mem_busy
  );
endinterface

// File: rtl/m_stage_ctrl_pipe.sv
// M-stage controller for the 5-stage MIPS pipeline.
// Owns the E/M register (instruction + address bits [1:0]), the load Tnew
// countdown, and the combinational decode of hazard info and memory strobes.
// Optional macro M_EXT_MEM_EN adds an IDLE/ACCESS FSM that waits on
// mem_ready and raises mem_busy; without it memory is single-cycle.
module m_stage_ctrl_pipe #(
  parameter int LOAD_LAT = 1,
  parameter int TNEW_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  m_stage_ctrl_pipe_if.slave   bus
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  localparam logic [TNEW_W-1:0] LAT = TNEW_W'(LOAD_LAT);

  typedef struct packed {
    logic load;
    logic store;
    logic misalign;
  } acc_t;

  // Memory-access class of an opcode at a given byte offset.
  function automatic acc_t classify(input logic [5:0] op, input logic [1:0] addr);
    acc_t a;
    a = '0;
    case (op)
      OP_LW:         begin a.load  = 1'b1; a.misalign = (addr != 2'b00); end
      OP_LH, OP_LHU: begin a.load  = 1'b1; a.misalign = addr[0];         end
      OP_LB, OP_LBU: a.load = 1'b1;
      OP_SW:         begin a.store = 1'b1; a.misalign = (addr != 2'b00); end
      OP_SH:         begin a.store = 1'b1; a.misalign = addr[0];         end
      OP_SB:         a.store = 1'b1;
      default:       ;
    endcase
    return a;
  endfunction

  logic [31:0]       instr_m_q;
  logic [1:0]        addr_m_q;
  logic [TNEW_W-1:0] tnew_q;
  logic              mem_busy;
  acc_t              acc_e;
  acc_t              acc_m;
  logic [TNEW_W-1:0] tnew_dec;

  assign acc_e    = classify(bus.instr_e[31:26], bus.addr_e);
  assign acc_m    = classify(instr_m_q[31:26], addr_m_q);
  assign tnew_dec = (tnew_q != '0) ? tnew_q - TNEW_W'(1) : '0;

  // E/M register: busy > stall > flush > capture.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_m_q <= '0;
      addr_m_q  <= '0;
      tnew_q    <= '0;
    end else if (mem_busy) begin
      instr_m_q <= instr_m_q;
      addr_m_q  <= addr_m_q;
      tnew_q    <= tnew_q;
    end else if (bus.stall_in) begin
      tnew_q    <= tnew_dec;
    end else if (bus.flush_in) begin
      instr_m_q <= '0;
      addr_m_q  <= '0;
      tnew_q    <= '0;
    end else begin
      instr_m_q <= bus.instr_e;
      addr_m_q  <= bus.addr_e;
      tnew_q    <= acc_e.load ? LAT : '0;
    end
  end

`ifdef M_EXT_MEM_EN
  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state_q, state_d;
  logic   new_access;

  assign new_access = !bus.stall_in && !bus.flush_in &&
                      (acc_e.load || acc_e.store) && !acc_e.misalign;

  // Access state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and busy: busy while an access is outstanding; a completing
  // access lets the register capture, which may start the next access.
  // NOTE: defaults assigned first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    mem_busy = 1'b0;
    case (state_q)
      IDLE:   if (new_access) state_d = ACCESS;
      ACCESS: begin
        if (!bus.mem_ready) mem_busy = 1'b1;
        else                state_d  = new_access ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`else
  assign mem_busy = 1'b0;
`endif

  // Decode of the instruction currently in M.
  always_comb begin
    bus.a3        = 5'd0;
    bus.jalop     = 1'b0;
    bus.change    = 1'b0;
    bus.memread   = acc_m.load  && !acc_m.misalign;
    bus.memwrite  = acc_m.store && !acc_m.misalign;
    bus.align_err = acc_m.misalign;
    bus.byte_en   = 4'b0000;
    case (instr_m_q[31:26])
      OP_SPECIAL: begin
        case (instr_m_q[5:0])
          FN_ADDU, FN_SUBU: bus.a3 = instr_m_q[15:11];
          FN_SLT, FN_SLTU: begin
            bus.a3     = instr_m_q[15:11];
            bus.change = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_LUI, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU:
        bus.a3 = instr_m_q[20:16];
      OP_JAL: begin
        bus.a3    = 5'd31;
        bus.jalop = 1'b1;
      end
      OP_SW: bus.byte_en = 4'b1111;
      OP_SH: bus.byte_en = addr_m_q[1] ? 4'b1100 : 4'b0011;
      OP_SB: bus.byte_en = 4'b0001 << addr_m_q;
      OP_J, OP_BEQ: ;
      default: ;
    endcase
    if (acc_m.misalign) bus.byte_en = 4'b0000;
  end

  assign bus.instr_m  = instr_m_q;
  assign bus.tnew     = tnew_q;
  assign bus.mem_busy = mem_busy;

endmodule

// File: tb/tb_m_stage_ctrl_pipe.sv
// Directed bench for m_stage_ctrl_pipe (LOAD_LAT=2, TNEW_W=2).
// Table of per-cycle vectors plus hand-written reset / memory-wait sequences.
module tb_m_stage_ctrl_pipe;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  m_stage_ctrl_pipe_if #(.TNEW_W(2)) bus ();

  m_stage_ctrl_pipe #(.LOAD_LAT(2), .TNEW_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  addr;
    logic        stall;
    logic        flush;
    logic [31:0] e_instr;
    logic [1:0]  e_tnew;
    logic [4:0]  e_a3;
    logic [8:0]  e_flags;   // {memwrite, memread, byte_en, jalop, change, align_err}
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] LW5   = 32'h8C050000;
  localparam logic [31:0] ADDU  = 32'h00222021;
  localparam logic [31:0] SLT   = 32'h0022182A;
  localparam logic [31:0] JAL   = 32'h0C000000;
  localparam logic [31:0] JMP   = 32'h08000000;
  localparam logic [31:0] SH2   = 32'hA4020000;
  localparam logic [31:0] SB2   = 32'hA0020000;
  localparam logic [31:0] SW2   = 32'hAC020000;
  localparam logic [31:0] LH6   = 32'h84060000;
  localparam logic [31:0] LB6   = 32'h80060000;
  localparam logic [31:0] ORI7  = 32'h34270005;
  localparam logic [31:0] BEQ   = 32'h10220000;

  function automatic logic [8:0] fl(input logic mw, input logic mr, input logic [3:0] be,
                                    input logic j, input logic c, input logic al);
    return {mw, mr, be, j, c, al};
  endfunction

  function automatic logic [8:0] dut_flags();
    return {bus.memwrite, bus.memread, bus.byte_en, bus.jalop, bus.change, bus.align_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input logic [31:0] instr, input logic [1:0] addr, input logic stall,
                     input logic flush, input logic [31:0] e_instr, input logic [1:0] e_tnew,
                     input logic [4:0] e_a3, input logic [8:0] e_flags);
    vec_t v;
    v.instr = instr; v.addr = addr; v.stall = stall; v.flush = flush;
    v.e_instr = e_instr; v.e_tnew = e_tnew; v.e_a3 = e_a3; v.e_flags = e_flags;
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_instr_m"}, bus.instr_m, 32'h0);
    check({tag, "_tnew"},    32'(bus.tnew), 32'h0);
    check({tag, "_a3"},      32'(bus.a3), 32'h0);
    check({tag, "_flags"},   32'(dut_flags()), 32'h0);
    check({tag, "_busy"},    32'(bus.mem_busy), 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.stall_in  = 1'b0;
    bus.flush_in  = 1'b0;
    bus.instr_e   = 32'h0;
    bus.addr_e    = 2'b00;
    bus.mem_ready = 1'b1;

    //            instr  addr  st  fl   exp instr  tnew a3   flags {mw,mr,be,j,c,al}
    add(LW5,  2'd0, 1'b0, 1'b0, LW5,  2'd2, 5'd5,  fl(0, 1, 4'b0000, 0, 0, 0));
    add(ADDU, 2'd0, 1'b1, 1'b0, LW5,  2'd1, 5'd5,  fl(0, 1, 4'b0000, 0, 0, 0));
    add(ADDU, 2'd0, 1'b1, 1'b0, LW5,  2'd0, 5'd5,  fl(0, 1, 4'b0000, 0, 0, 0));
    add(ADDU, 2'd0, 1'b1, 1'b0, LW5,  2'd0, 5'd5,  fl(0, 1, 4'b0000, 0, 0, 0));
    add(ADDU, 2'd0, 1'b1, 1'b1, LW5,  2'd0, 5'd5,  fl(0, 1, 4'b0000, 0, 0, 0));
    add(ADDU, 2'd0, 1'b0, 1'b0, ADDU, 2'd0, 5'd4,  fl(0, 0, 4'b0000, 0, 0, 0));
    add(SLT,  2'd0, 1'b0, 1'b0, SLT,  2'd0, 5'd3,  fl(0, 0, 4'b0000, 0, 1, 0));
    add(JAL,  2'd0, 1'b0, 1'b0, JAL,  2'd0, 5'd31, fl(0, 0, 4'b0000, 1, 0, 0));
    add(JMP,  2'd0, 1'b0, 1'b0, JMP,  2'd0, 5'd0,  fl(0, 0, 4'b0000, 0, 0, 0));
    add(SH2,  2'd2, 1'b0, 1'b0, SH2,  2'd0, 5'd0,  fl(1, 0, 4'b1100, 0, 0, 0));
    add(SH2,  2'd0, 1'b0, 1'b0, SH2,  2'd0, 5'd0,  fl(1, 0, 4'b0011, 0, 0, 0));
    add(SB2,  2'd3, 1'b0, 1'b0, SB2,  2'd0, 5'd0,  fl(1, 0, 4'b1000, 0, 0, 0));
    add(SB2,  2'd1, 1'b0, 1'b0, SB2,  2'd0, 5'd0,  fl(1, 0, 4'b0010, 0, 0, 0));
    add(SH2,  2'd1, 1'b0, 1'b0, SH2,  2'd0, 5'd0,  fl(0, 0, 4'b0000, 0, 0, 1));
    add(SW2,  2'd0, 1'b0, 1'b0, SW2,  2'd0, 5'd0,  fl(1, 0, 4'b1111, 0, 0, 0));
    add(SW2,  2'd2, 1'b0, 1'b0, SW2,  2'd0, 5'd0,  fl(0, 0, 4'b0000, 0, 0, 1));
    add(LH6,  2'd1, 1'b0, 1'b0, LH6,  2'd2, 5'd6,  fl(0, 0, 4'b0000, 0, 0, 1));
    add(LB6,  2'd3, 1'b0, 1'b0, LB6,  2'd2, 5'd6,  fl(0, 1, 4'b0000, 0, 0, 0));
    add(ORI7, 2'd0, 1'b0, 1'b0, ORI7, 2'd0, 5'd7,  fl(0, 0, 4'b0000, 0, 0, 0));
    add(LW5,  2'd0, 1'b0, 1'b1, 32'h0, 2'd0, 5'd0, fl(0, 0, 4'b0000, 0, 0, 0));
    add(BEQ,  2'd0, 1'b0, 1'b0, BEQ,  2'd0, 5'd0,  fl(0, 0, 4'b0000, 0, 0, 0));
    add(LW5,  2'd1, 1'b0, 1'b0, LW5,  2'd2, 5'd5,  fl(0, 0, 4'b0000, 0, 0, 1));
    add(LW5,  2'd0, 1'b0, 1'b0, LW5,  2'd2, 5'd5,  fl(0, 1, 4'b0000, 0, 0, 0));

    // Reset state before any clock edge is released.
    #2;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      bus.instr_e  = vecs[i].instr;
      bus.addr_e   = vecs[i].addr;
      bus.stall_in = vecs[i].stall;
      bus.flush_in = vecs[i].flush;
      tick();
      check($sformatf("v%0d_instr_m", i), bus.instr_m, vecs[i].e_instr);
      check($sformatf("v%0d_tnew", i),    32'(bus.tnew), 32'(vecs[i].e_tnew));
      check($sformatf("v%0d_a3", i),      32'(bus.a3), 32'(vecs[i].e_a3));
      check($sformatf("v%0d_flags", i),   32'(dut_flags()), 32'(vecs[i].e_flags));
    end
    bus.stall_in = 1'b0;
    bus.flush_in = 1'b0;

    // Asynchronous reset with lw sitting in M: outputs clear before the next edge.
    check("pre_reset_memread", 32'(bus.memread), 32'h1);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;

`ifdef M_EXT_MEM_EN
    // sw waits three cycles on memory, then the next instruction enters.
    bus.mem_ready = 1'b0;
    bus.instr_e   = SW2;
    bus.addr_e    = 2'd0;
    tick();
    check("ext_c0_busy", 32'(bus.mem_busy), 32'h1);
    check("ext_c0_mw",   32'(dut_flags()), 32'(fl(1, 0, 4'b1111, 0, 0, 0)));
    bus.instr_e  = ADDU;
    bus.flush_in = 1'b1;
    for (int c = 1; c < 3; c++) begin
      tick();
      check($sformatf("ext_c%0d_busy", c),  32'(bus.mem_busy), 32'h1);
      check($sformatf("ext_c%0d_instr", c), bus.instr_m, SW2);
      check($sformatf("ext_c%0d_mw", c),    32'(dut_flags()), 32'(fl(1, 0, 4'b1111, 0, 0, 0)));
    end
    bus.flush_in  = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("ext_ready_busy", 32'(bus.mem_busy), 32'h0);
    tick();
    check("ext_next_instr", bus.instr_m, ADDU);
    check("ext_next_busy",  32'(bus.mem_busy), 32'h0);

    // Load waiting on memory keeps tnew frozen, then counts down once ready.
    bus.mem_ready = 1'b0;
    bus.instr_e   = LW5;
    tick();
    bus.stall_in = 1'b1;
    tick();
    tick();
    check("ext_lw_tnew_frozen", 32'(bus.tnew), 32'h2);
    check("ext_lw_memread",     32'(bus.memread), 32'h1);
    bus.mem_ready = 1'b1;
    tick();
    check("ext_lw_tnew_dec", 32'(bus.tnew), 32'h1);
    bus.stall_in = 1'b0;

    // Reset mid-access drops strobes and busy at once.
    bus.mem_ready = 1'b0;
    bus.instr_e   = SW2;
    tick();
    check("ext_pre_reset_busy", 32'(bus.mem_busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("ext_reset");
    bus.mem_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
`else
    // Single-cycle memory: mem_ready is ignored and busy never rises.
    bus.mem_ready = 1'b0;
    bus.instr_e   = SW2;
    bus.addr_e    = 2'd0;
    tick();
    check("nobusy_busy",  32'(bus.mem_busy), 32'h0);
    bus.instr_e = ADDU;
    tick();
    check("nobusy_instr", bus.instr_m, ADDU);
    bus.mem_ready = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/m_stage_ctrl_pipe.md
Name: m_stage_ctrl_pipe

Overview:
- Next-generation M-stage controller for the 5-stage MIPS pipeline.
- Owns the E/M pipeline register for the instruction and the low address bits.
- Decodes the registered instruction into hazard info (tnew, a3) and memory controls.
- Adds a load-latency Tnew countdown, sub-word store byte enables, stall/flush control and an optional data-memory ready handshake.

Parameters:
- LOAD_LAT, 1, cycles after entering M until load data is forwardable; the loaded tnew value. Range 1..(2^TNEW_W-1).
- TNEW_W, 2, width of tnew.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- stall_in  in  1  hold M register contents (hazard unit)
- flush_in  in  1  load a bubble (instr 0) instead of instr_e
- instr_e  in  32  instruction leaving E
- addr_e  in  2  ALU result bits [1:0] leaving E
- mem_ready  in  1  data memory completed access (used only with M_EXT_MEM_EN)
- instr_m  out  32  registered instruction
- tnew  out  TNEW_W  cycles until the result is available
- a3  out  5  destination register; 0 if none
- memwrite  out  1  store strobe
- memread  out  1  load strobe
- byte_en  out  4  store byte lanes
- jalop  out  1  jal in M
- change  out  1  slt/sltu in M
- align_err  out  1  misaligned access in M
- mem_busy  out  1  M blocked on memory; upstream must stall

Behaviour:
- Reset (async, reset_n=0): instr_m=0, addr_m=0, tnew=0, state IDLE.
  - All decoded outputs follow the NOP decode: every output 0.
- Register update priority at posedge: mem_busy > stall_in > flush_in > capture.
  - mem_busy=1 or stall_in=1: hold instr_m and addr_m.
  - flush_in=1: instr_m=0.
  - Otherwise instr_m<=instr_e, addr_m<=addr_e.
- tnew on capture: LOAD_LAT for loads (lw, lb, lbu, lh, lhu); 0 otherwise.
  - While held: decrement by 1 per cycle, saturating at 0.
  - Flush sets tnew to 0.
- Decode is combinational from instr_m.
  - addu, subu, slt, sltu: a3=rd. change=1 only for slt and sltu.
  - ori, lui, loads: a3=rt.
  - jal: a3=31, jalop=1.
  - sw, sb, sh, beq, jr, j (opcode 000010), unknown: a3=0.
- memread: 1 for loads. memwrite: 1 for aligned stores.
- byte_en (stores only, else 0):
  - sw: 1111.
  - sh: addr_m[1] ? 1100 : 0011.
  - sb: 0001 << addr_m.
- align_err:
  - (sw or lw) with addr_m≠0.
  - (sh or lh or lhu) with addr_m[0]=1.
  - When align_err=1: memwrite=0, memread=0, byte_en=0.
- a3=0 is never reported as a write (register 0 is not a hazard).

Optional Feature:
- M_EXT_MEM_EN defined: FSM states IDLE and ACCESS.
  - IDLE→ACCESS when a new aligned load or store is captured.
  - In ACCESS: mem_busy=!mem_ready. memread, memwrite and byte_en held stable.
  - tnew frozen (no decrement) until mem_ready.
  - ACCESS→IDLE on mem_ready=1; the pipeline register may capture the next instruction in that same cycle.
  - Reset mid-ACCESS returns to IDLE and drops the strobes immediately.
  - flush_in while mem_busy is ignored.
- M_EXT_MEM_EN undefined: no FSM, mem_busy tied 0, mem_ready ignored, single-cycle memory.

Test Plan:
- Reset mid-run with instr_m=lw: reset_n=0 → all outputs 0 asynchronously, before the next clk edge.
- LOAD_LAT=2, capture lw $5 (0x8C050000), then stall_in=1 for 3 cycles → tnew 2,1,0,0; a3=5; memread=1 throughout.
- sh with addr_e=2 → byte_en=1100, memwrite=1. sb with addr_e=3 → 1000. sh with addr_e=1 → align_err=1, memwrite=0, byte_en=0.
- slt $3,$1,$2 (0x0022182A) → a3=3, change=1, tnew=0. jal → a3=31, jalop=1. j (0x08000000) → a3=0.
- flush_in=1 together with instr_e=lw → instr_m=0, tnew=0, all strobes 0. stall_in and flush_in both 1 → hold (stall wins).
- M_EXT_MEM_EN: sw captured, mem_ready low for 3 cycles → mem_busy=1 for 3 cycles, memwrite stable, instr_m held. On mem_ready=1 → mem_busy=0 and the next instruction captured on that edge.
